sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Display-output stage downstream of the sprite engines. Merges two 1-bit sprite pixel
//  streams onto a background colour, applies per-sprite colours and drives the VGA pins.
//  Delays hsync/vsync/de so they stay aligned with the registered colour path.
//  Also detects sprite-sprite overlap and reports it once per frame for game logic.
// PARAMETERS
//  COLRW     4       bits per colour channel; packed colour is 3*COLRW, {R,G,B}
//  CNTW      8       width of the collision-frame counter
//  SYNC_IDLE 1       level driven on vga_hsync/vga_vsync during reset (1 = active-low syncs)
// PORTS
//  clk        in   1        pixel clock
//  rst_n      in   1        reset; asynchronous, active-low
//  frame      in   1        one-cycle strobe at start of vertical blanking
//  de         in   1        data enable from display timings
//  hsync      in   1        horizontal sync from display timings
//  vsync      in   1        vertical sync from display timings
//  spr0_pix   in   1        sprite 0 pixel (priority sprite)
//  spr1_pix   in   1        sprite 1 pixel
//  spr0_colr  in   3*COLRW  sprite 0 colour
//  spr1_colr  in   3*COLRW  sprite 1 colour
//  bg_colr    in   3*COLRW  background colour
//  vga_hsync  out  1        delayed hsync
//  vga_vsync  out  1        delayed vsync
//  vga_r/g/b  out  COLRW    output colour channels
//  collision  out  1        1 if sprites overlapped in visible area during previous frame
//  coll_cnt   out  CNTW     count of frames containing a collision, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): vga_hsync=vga_vsync=SYNC_IDLE, vga_r/g/b=0, collision=0,
//    coll_cnt=0, all pipeline registers cleared (de stages 0, sync stages SYNC_IDLE).
//  - Pipeline, fixed latency 2 cycles from inputs to all VGA outputs:
//    S1: register de, hsync, vsync, spr0_pix, spr1_pix, colours.
//    S2: select colour, register onto vga_*; syncs pass through same two registers.
//  - S2 select: !de_s1 -> 0; spr0_s1 -> spr0_colr; else spr1_s1 -> spr1_colr; else bg_colr.
//  - Colour inputs are sampled in S1 with the pixel; a colour change mid-line takes
//    effect on the pixel sampled in the same cycle.
//  - Collision accumulator coll_acc: set when de_s1 && spr0_s1 && spr1_s1.
//  - On frame=1: collision <= coll_acc | hit_now (hit_now = overlap term this cycle);
//    coll_acc <= 0; if that value is 1 and coll_cnt != all-ones, coll_cnt <= coll_cnt+1.
//  - frame while the S1 overlap term is true: counted in the closing frame, not the new one.
//  - Overlap with de_s1=0 (blanking) never counts.
//  - coll_cnt saturates at 2**CNTW-1; only reset clears it.
//  - collision holds its value for a whole frame; updated only on frame strobes.
//  - Reset mid-frame discards coll_acc; first frame strobe after reset reports that
//    partial frame only.
// CONFIGURATION
//  COMPOSITOR_BLEND_EN defined: when spr0_s1 && spr1_s1 && de_s1, each channel output
//    = (c0 + c1) >> 1, computed at COLRW+1 bits and truncated. Other pixels as above.
//  COMPOSITOR_BLEND_EN undefined: spr0 always wins overlap; no adders synthesised.
//  Latency, sync alignment and collision logic are identical in both builds.
// TESTING
//  1 rst_n=0 mid-line -> immediately vga_r/g/b=0, syncs=SYNC_IDLE, coll_cnt=0;
//    release -> first valid colour 2 cycles after first input.
//  2 de=1, spr0=1, spr0_colr=12'hFC0 at cycle N -> vga_r/g/b=F/C/0 at N+2; hsync pulse
//    input at N -> output pulse at N+2, same width.
//  3 de=1, no sprites, bg_colr=12'h123 -> 1/2/3; de=0 with spr0=1 -> 0/0/0.
//  4 overlap spr0=spr1=1, de=1 for 3 pixels in frame -> next frame strobe: collision=1,
//    coll_cnt=1; following clean frame -> collision=0, coll_cnt stays 1.
//  5 overlap coincident with frame strobe -> counted in closing frame; overlap only in
//    blanking -> collision=0.
//  6 CNTW=2, 5 colliding frames -> coll_cnt=3. With COMPOSITOR_BLEND_EN, spr0=12'hF00,
//    spr1=12'h0F0 overlap -> 7/7/0; without -> F/0/0.

Source files
------------

// File: rtl/sprite_compositor.sv
// -----------------------------------------------------------------------------
// sprite_compositor
//
// Display-output stage that sits after the sprite engines. Two 1-bit sprite
// pixel streams are merged onto a background colour, each sprite gets its own
// colour, and the result drives the VGA pins. hsync/vsync/de travel through the
// same two register stages as the colour, so the syncs stay aligned with it.
// Sprite-sprite overlap in the visible area is accumulated over a frame and
// reported on each frame strobe. A saturating counter tracks how many frames
// contained a collision.
//
// Optional build macro: COMPOSITOR_BLEND_EN
//   defined   -> overlapping visible sprite pixels output the per-channel
//                average (c0 + c1) >> 1.
//   undefined -> sprite 0 always wins an overlap (no adders built).
//   Latency, sync alignment and collision behaviour are the same in both builds.
//
// Parameters
//   COLRW      bits per colour channel (packed colour is {R,G,B}, 3*COLRW bits)
//   CNTW       width of the collision-frame counter
//   SYNC_IDLE  level driven on vga_hsync/vga_vsync while in reset
//
// Ports
//   clk        in   pixel clock
//   rst_n      in   asynchronous active-low reset
//   frame      in   one-cycle strobe at start of vertical blanking
//   de         in   data enable from display timings
//   hsync      in   horizontal sync from display timings
//   vsync      in   vertical sync from display timings
//   spr0_pix   in   sprite 0 pixel (priority sprite)
//   spr1_pix   in   sprite 1 pixel
//   spr0_colr  in   sprite 0 colour
//   spr1_colr  in   sprite 1 colour
//   bg_colr    in   background colour
//   vga_hsync  out  hsync delayed by 2 cycles
//   vga_vsync  out  vsync delayed by 2 cycles
//   vga_r/g/b  out  output colour channels, 2 cycles after the input pixel
//   collision  out  1 if sprites overlapped in the visible area last frame
//   coll_cnt   out  saturating count of frames that contained a collision
// -----------------------------------------------------------------------------
module sprite_compositor #(
    parameter int   COLRW     = 4,
    parameter int   CNTW      = 8,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame,
    input  logic                 de,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 spr0_pix,
    input  logic                 spr1_pix,
    input  logic [3*COLRW-1:0]   spr0_colr,
    input  logic [3*COLRW-1:0]   spr1_colr,
    input  logic [3*COLRW-1:0]   bg_colr,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [COLRW-1:0]     vga_r,
    output logic [COLRW-1:0]     vga_g,
    output logic [COLRW-1:0]     vga_b,
    output logic                 collision,
    output logic [CNTW-1:0]      coll_cnt
);

    localparam int CW = 3 * COLRW;

    // Stage 1: everything sampled together so a mid-line colour change
    // applies to the pixel captured in the same cycle.
    logic          de_s1;
    logic          hsync_s1;
    logic          vsync_s1;
    logic          spr0_s1;
    logic          spr1_s1;
    logic [CW-1:0] spr0_colr_s1;
    logic [CW-1:0] spr1_colr_s1;
    logic [CW-1:0] bg_colr_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_s1        <= 1'b0;
            hsync_s1     <= SYNC_IDLE;
            vsync_s1     <= SYNC_IDLE;
            spr0_s1      <= 1'b0;
            spr1_s1      <= 1'b0;
            spr0_colr_s1 <= '0;
            spr1_colr_s1 <= '0;
            bg_colr_s1   <= '0;
        end else begin
            de_s1        <= de;
            hsync_s1     <= hsync;
            vsync_s1     <= vsync;
            spr0_s1      <= spr0_pix;
            spr1_s1      <= spr1_pix;
            spr0_colr_s1 <= spr0_colr;
            spr1_colr_s1 <= spr1_colr;
            bg_colr_s1   <= bg_colr;
        end
    end

`ifdef COMPOSITOR_BLEND_EN
    // Per-channel average; the extra sum bit keeps the carry so the
    // shift yields a true (c0 + c1) / 2 truncated to COLRW bits.
    logic [CW-1:0] blend_colr;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_blend
            logic [COLRW:0] sum;
            assign sum = {1'b0, spr0_colr_s1[gi*COLRW +: COLRW]}
                       + {1'b0, spr1_colr_s1[gi*COLRW +: COLRW]};
            assign blend_colr[gi*COLRW +: COLRW] = sum[COLRW:1];
        end
    endgenerate
`endif

    // Stage 2 colour select: blanking forces black, sprite 0 has priority.
    logic [CW-1:0] colr_next;

    always_comb begin
        colr_next = '0;
        if (!de_s1) begin
            colr_next = '0;
        end
`ifdef COMPOSITOR_BLEND_EN
        else if (spr0_s1 && spr1_s1) begin
            colr_next = blend_colr;
        end
`endif
        else if (spr0_s1) begin
            colr_next = spr0_colr_s1;
        end else if (spr1_s1) begin
            colr_next = spr1_colr_s1;
        end else begin
            colr_next = bg_colr_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hsync <= SYNC_IDLE;
            vga_vsync <= SYNC_IDLE;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            vga_hsync <= hsync_s1;
            vga_vsync <= vsync_s1;
            vga_r     <= colr_next[CW-1 -: COLRW];
            vga_g     <= colr_next[2*COLRW-1 -: COLRW];
            vga_b     <= colr_next[COLRW-1 -: COLRW];
        end
    end

    // Collision tracking. hit_now is folded into the frame-strobe result so an
    // overlap coincident with the strobe belongs to the frame that is closing.
    logic coll_acc;
    logic hit_now;
    logic frame_hit;

    assign hit_now   = de_s1 & spr0_s1 & spr1_s1;
    assign frame_hit = coll_acc | hit_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_acc  <= 1'b0;
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else if (frame) begin
            collision <= frame_hit;
            coll_acc  <= 1'b0;
            if (frame_hit && (coll_cnt != {CNTW{1'b1}})) begin
                coll_cnt <= coll_cnt + CNTW'(1);
            end
        end else begin
            coll_acc <= frame_hit;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// -----------------------------------------------------------------------------
// tb_sprite_compositor
//
// Directed bench for sprite_compositor (COLRW=4, CNTW=2 so saturation is
// reachable in a few frames). Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so a value driven before edge k shows
// on the VGA pins after edge k+1.
// -----------------------------------------------------------------------------
module tb_sprite_compositor;

    localparam int COLRW = 4;
    localparam int CNTW  = 2;

`ifdef COMPOSITOR_BLEND_EN
    localparam logic [11:0] EXP_OVL = 12'h770;
`else
    localparam logic [11:0] EXP_OVL = 12'hF00;
`endif

    logic             clk;
    logic             rst_n;
    logic             frame;
    logic             de;
    logic             hsync;
    logic             vsync;
    logic             spr0_pix;
    logic             spr1_pix;
    logic [11:0]      spr0_colr;
    logic [11:0]      spr1_colr;
    logic [11:0]      bg_colr;
    logic             vga_hsync;
    logic             vga_vsync;
    logic [3:0]       vga_r;
    logic [3:0]       vga_g;
    logic [3:0]       vga_b;
    logic             collision;
    logic [CNTW-1:0]  coll_cnt;
    logic [11:0]      rgb;

    int check_cnt = 0;
    int pass_cnt  = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    sprite_compositor #(
        .COLRW     (COLRW),
        .CNTW      (CNTW),
        .SYNC_IDLE (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame     (frame),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .spr0_pix  (spr0_pix),
        .spr1_pix  (spr1_pix),
        .spr0_colr (spr0_colr),
        .spr1_colr (spr1_colr),
        .bg_colr   (bg_colr),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .collision (collision),
        .coll_cnt  (coll_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        frame     = 1'b0;
        de        = 1'b0;
        hsync     = 1'b1;
        vsync     = 1'b1;
        spr0_pix  = 1'b0;
        spr1_pix  = 1'b0;
        spr0_colr = 12'h000;
        spr1_colr = 12'h000;
        bg_colr   = 12'h000;

        // Held in reset
        tick();
        check("rst_rgb", 32'(rgb), 32'h000);
        check("rst_hs", 32'(vga_hsync), 32'h1);
        check("rst_vs", 32'(vga_vsync), 32'h1);
        check("rst_coll", 32'(collision), 32'h0);
        check("rst_cnt", 32'(coll_cnt), 32'h0);

        // Background, syncs low; two-cycle latency
        rst_n   = 1'b1;
        de      = 1'b1;
        bg_colr = 12'h123;
        hsync   = 1'b0;
        vsync   = 1'b0;
        tick();
        check("bg_lat1", 32'(rgb), 32'h000);
        tick();
        check("bg_rgb", 32'(rgb), 32'h123);
        check("bg_hs", 32'(vga_hsync), 32'h0);
        check("bg_vs", 32'(vga_vsync), 32'h0);

        // Asynchronous reset mid-line
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rgb", 32'(rgb), 32'h000);
        check("arst_hs", 32'(vga_hsync), 32'h1);
        check("arst_vs", 32'(vga_vsync), 32'h1);
        tick();
        rst_n = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        tick();
        check("rel_lat1", 32'(rgb), 32'h000);
        tick();
        check("rel_rgb", 32'(rgb), 32'h123);

        // Sprite 0 colour plus a 2-cycle hsync pulse
        spr0_pix  = 1'b1;
        spr0_colr = 12'hFC0;
        hsync     = 1'b0;
        tick();
        check("hs_lat1", 32'(vga_hsync), 32'h1);
        check("spr0_lat1", 32'(rgb), 32'h123);
        tick();
        check("hs_start", 32'(vga_hsync), 32'h0);
        check("spr0_rgb", 32'(rgb), 32'hFC0);
        hsync = 1'b1;
        tick();
        check("hs_width", 32'(vga_hsync), 32'h0);
        tick();
        check("hs_end", 32'(vga_hsync), 32'h1);

        // Blanking with sprite 0 on -> black
        de = 1'b0;
        tick();
        tick();
        check("blank_rgb", 32'(rgb), 32'h000);

        // Sprite 1 alone
        de        = 1'b1;
        spr0_pix  = 1'b0;
        spr1_pix  = 1'b1;
        spr1_colr = 12'h0F0;
        tick();
        tick();
        check("spr1_rgb", 32'(rgb), 32'h0F0);
        spr1_pix = 1'b0;
        tick();
        tick();

        // Clean frame start, then 3 overlapping pixels
        pulse_frame();
        check("f0_coll", 32'(collision), 32'h0);
        spr0_colr = 12'hF00;
        spr1_colr = 12'h0F0;
        spr0_pix  = 1'b1;
        spr1_pix  = 1'b1;
        tick();
        tick();
        check("ovl_rgb", 32'(rgb), 32'(EXP_OVL));
        tick();
        spr0_pix = 1'b0;
        spr1_pix = 1'b0;
        tick();
        tick();
        check("ovl_hold", 32'(collision), 32'h0);
        pulse_frame();
        check("f1_coll", 32'(collision), 32'h1);
        check("f1_cnt", 32'(coll_cnt), 32'h1);

        // Clean frame
        tick();
        tick();
        tick();
        pulse_frame();
        check("f2_coll", 32'(collision), 32'h0);
        check("f2_cnt", 32'(coll_cnt), 32'h1);

        // Overlap in S1 exactly when frame is strobed
        spr0_pix = 1'b1;
        spr1_pix = 1'b1;
        tick();
        spr0_pix = 1'b0;
        spr1_pix = 1'b0;
        pulse_frame();
        check("f3_coll", 32'(collision), 32'h1);
        check("f3_cnt", 32'(coll_cnt), 32'h2);
        tick();
        tick();
        tick();
        pulse_frame();
        check("f4_coll", 32'(collision), 32'h0);
        check("f4_cnt", 32'(coll_cnt), 32'h2);

        // Overlap only during blanking
        de       = 1'b0;
        spr0_pix = 1'b1;
        spr1_pix = 1'b1;
        tick();
        tick();
        check("bovl_rgb", 32'(rgb), 32'h000);
        spr0_pix = 1'b0;
        spr1_pix = 1'b0;
        tick();
        tick();
        pulse_frame();
        check("f5_coll", 32'(collision), 32'h0);
        check("f5_cnt", 32'(coll_cnt), 32'h2);

        // Three more colliding frames: 2 -> 3, then held at 3
        de = 1'b1;
        for (int k = 0; k < 3; k++) begin
            spr0_pix = 1'b1;
            spr1_pix = 1'b1;
            tick();
            spr0_pix = 1'b0;
            spr1_pix = 1'b0;
            tick();
            tick();
            pulse_frame();
            check($sformatf("sat%0d_coll", k), 32'(collision), 32'h1);
            check($sformatf("sat%0d_cnt", k), 32'(coll_cnt), 32'h3);
        end

        // Reset in the middle of a colliding frame discards the accumulator
        spr0_pix = 1'b1;
        spr1_pix = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_coll", 32'(collision), 32'h0);
        check("mrst_cnt", 32'(coll_cnt), 32'h0);
        check("mrst_rgb", 32'(rgb), 32'h000);
        spr0_pix = 1'b0;
        spr1_pix = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        pulse_frame();
        check("mrst_fcoll", 32'(collision), 32'h0);
        check("mrst_fcnt", 32'(coll_cnt), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
